// File: rtl/bp_resolve_fifo.sv
// bp_resolve_fifo: in-order FIFO of predicted branches for the gshare predictor.
// Fetch pushes {alias, predicted direction}. Execute resolves the oldest entry.
// The block emits a registered predictor-update bundle and a mispredict pulse.
// A mispredict or an external flush discards every remaining entry.
// Optional build macro BP_RESOLVE_STATS_EN adds saturating branch and
// mispredict counters (stat_branches, stat_mispred).
module bp_resolve_fifo #(
  parameter int DEPTH   = 8,
  parameter int ALIAS_W = 6,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ALIAS_W-1:0] push_alias,
  input  logic               push_pred,
  input  logic               resolve,
  input  logic               resolve_taken,
  input  logic               flush,
  output logic               prev_is_BR,
  output logic               prev_BR_result,
  output logic [ALIAS_W-1:0] prev_BR_alias,
  output logic               mispredict,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
`ifdef BP_RESOLVE_STATS_EN
  ,
  output logic [15:0]        stat_branches,
  output logic [15:0]        stat_mispred
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ALIAS_W-1:0] br_alias;
    logic               pred;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  entry_t             head;
  logic               pop_ok;
  logic               squash;
  logic               push_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Decode pop, squash and accepted push from the current state and requests.
  always_comb begin
    head    = mem[rd_ptr];
    pop_ok  = resolve && !empty;
    squash  = pop_ok && (head.pred ^ resolve_taken);
    // A push is discarded when it lands on wrong-path state (squash or flush).
    push_ok = push && (!full || pop_ok) && !squash && !flush;
  end

  // Entry storage write.
  // NOTE: the storage array is not reset; entries are only read once the
  // pointers and count say they are valid, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= '{br_alias: push_alias, pred: push_pred};
    end
  end

  // Pointer and occupancy bookkeeping; squash/flush collapse the queue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (squash || flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered predictor-update bundle; strobes pulse for one cycle per pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_is_BR     <= 1'b0;
      prev_BR_result <= 1'b0;
      prev_BR_alias  <= '0;
      mispredict     <= 1'b0;
    end else begin
      prev_is_BR     <= pop_ok;
      prev_BR_result <= pop_ok && resolve_taken;
      mispredict     <= squash;
      if (pop_ok) prev_BR_alias <= head.br_alias;
    end
  end

`ifdef BP_RESOLVE_STATS_EN
  // Saturating counts of resolved branches and mispredictions.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop_ok && stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (squash && stat_mispred != 16'hFFFF)  stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: doc/bp_resolve_fifo.md
Name: bp_resolve_fifo

Overview:
- Resolution-side partner of the gshare predictor.
- Fetch pushes each predicted branch's PHT alias and predicted direction into an in-order FIFO. When execute resolves branches in order, the oldest entry is popped and compared with the actual outcome.
- Drives the predictor update bundle (prev_is_BR, prev_BR_result, prev_BR_alias) and a mispredict pulse that squashes younger in-flight entries.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of 2, minimum 2.
- ALIAS_W, 6, PHT alias width; must equal predictor BP_alias width.
- CNT_W, 4, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- push  in  1  fetch issued a predicted branch this cycle.
- push_alias  in  ALIAS_W  BP_alias used for the prediction.
- push_pred  in  1  predicted direction (1 = taken).
- resolve  in  1  oldest in-flight branch resolved this cycle.
- resolve_taken  in  1  actual direction of the resolving branch.
- flush  in  1  external pipeline flush; discards all entries.
- prev_is_BR  out  1  registered one-cycle update strobe to predictor.
- prev_BR_result  out  1  registered actual outcome.
- prev_BR_alias  out  ALIAS_W  registered alias of the resolved entry.
- mispredict  out  1  registered one-cycle pulse; prediction != outcome.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CNT_W  current occupancy.

Behaviour:
- Storage: circular buffer of {alias, pred} entries with read and write pointers of log2(DEPTH) bits each. Pointers wrap modulo DEPTH. Count is tracked separately in CNT_W bits.
- Reset (synchronous, active-high):
  - pointers = 0, count = 0, empty = 1, full = 0.
  - prev_is_BR, prev_BR_result, prev_BR_alias, mispredict = 0.
  - Reset overrides push, resolve and flush in the same cycle.
- Push accepted iff push && (!full || pop_ok). Writes the entry at the write pointer, and the write pointer increments. A push while full with no pop is dropped silently; state is unchanged.
- pop_ok = resolve && !empty. A resolve while empty is ignored: no strobe, no mispredict.
- On pop_ok, the update is presented the following cycle (latency 1):
  - prev_is_BR = 1.
  - prev_BR_result = resolve_taken.
  - prev_BR_alias = the popped entry's alias.
  - mispredict = popped pred XOR resolve_taken.
  - All four outputs are pulses: they return to 0 (alias holds its last value) on any cycle with no pop.
- Mispredict squash: if the popped entry mispredicts, all remaining entries are wrong-path.
  - At that edge: count = 0, and read pointer = write pointer.
  - A push in the same cycle is discarded.
- Flush: at that edge, count = 0 and read pointer = write pointer. A simultaneous valid resolve is still processed first; its update strobe and mispredict are emitted normally. A simultaneous push is discarded.
- Simultaneous push and pop with no squash: count is unchanged and both pointers advance. This is legal when full.
- Count arithmetic: +1 on push only, -1 on pop only, unchanged on both or neither. Squash or flush forces 0.
- full and empty are combinational from count.

Optional Feature:
- Macro: BP_RESOLVE_STATS_EN
- When defined, adds outputs stat_branches[15:0] and stat_mispred[15:0]:
  - Saturating counters, cleared by reset.
  - Increment at the edge where prev_is_BR / mispredict is set.
  - Hold at 16'hFFFF once saturated.
- When undefined: ports and logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset, then push {alias=6'h15, pred=1}, then resolve with taken=1 -> next cycle prev_is_BR=1, prev_BR_alias=6'h15, prev_BR_result=1, mispredict=0; count returns to 0.
- Push 8 entries, aliases 0..7 -> full=1. Then push alias 6'h3F alone -> dropped, count stays 8. Then 8 resolves -> aliases popped in order 0..7, empty=1.
- Push 3 entries, pred=1 each; resolve first with taken=0 -> mispredict=1 next cycle, count=0. A further resolve -> no strobe.
- Full FIFO, push+resolve same cycle (correct prediction) -> count stays 8, new entry popped last after wrap-around.
- Push 2 entries; flush with simultaneous resolve taken=pred -> strobe emitted for entry 0, mispredict=0, count=0. Assert reset mid-stream -> all outputs 0 next cycle.
- With BP_RESOLVE_STATS_EN: 5 resolves, 2 mispredicted -> stat_branches=5, stat_mispred=2.
